// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the shared register-array write port.
// Also holds the pending-write scoreboard that issue logic stalls on.
module regfile_wb_arbiter #(
   parameter int NREQ   = 3,
   parameter int DATA_W = 32,
   parameter int NREGS  = 32
) (
   input  logic                   clk_i,
   input  logic                   resetn_i,
   input  logic [NREQ-1:0]        req_valid_i,
   input  logic [5*NREQ-1:0]      req_rd_i,
   input  logic [DATA_W*NREQ-1:0] req_data_i,
   output logic [NREQ-1:0]        req_ready_o,
   output logic [DATA_W-1:0]      G_o,
   output logic [NREGS-1:0]       R_in_o,
   input  logic                   alloc_valid_i,
   input  logic [4:0]             alloc_rd_i,
   output logic                   alloc_ready_o,
   output logic [NREGS-1:0]       pending_o
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef struct packed {
      logic [4:0]        rd;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   wb_req_t [NREQ-1:0] req;
   wb_req_t            wb_sel;

   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d, gnt_idx, cand;
   logic              xfer;
   logic [DATA_W-1:0] G_q, G_d;
   logic [NREGS-1:0]  R_in_q, R_in_d, pending_q, pending_d;

   for (genvar i = 0; i < NREQ; i++) begin : g_req
      assign req[i].rd   = req_rd_i[5*i +: 5];
      assign req[i].data = req_data_i[DATA_W*i +: DATA_W];
   end

   // Register 0 is hardwired, so its decode bit is never set.
   function automatic logic [NREGS-1:0] onehot(input logic [4:0] rd);
      logic [NREGS-1:0] oh;
      oh = '0;
      for (int r = 1; r < NREGS; r++) oh[r] = (rd == 5'(r));
      return oh;
   endfunction

   // Search starts one past the last winner and wraps; no grants in reset.
   always_comb begin
      xfer    = 1'b0;
      gnt_idx = rr_ptr_q;
      cand    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
         if (!xfer && resetn_i && req_valid_i[cand]) begin
            xfer    = 1'b1;
            gnt_idx = cand;
         end
      end
      req_ready_o          = '0;
      req_ready_o[gnt_idx] = xfer;
   end

   assign wb_sel        = req[gnt_idx];
   assign alloc_ready_o = (alloc_rd_i == 5'd0) | ~pending_q[alloc_rd_i];

   always_comb begin
      rr_ptr_d = xfer ? gnt_idx : rr_ptr_q;
      G_d      = xfer ? wb_sel.data : G_q;
      R_in_d   = xfer ? onehot(wb_sel.rd) : '0;
      // Clear for the write being retired this cycle, then any new reservation.
      pending_d = pending_q & ~R_in_q;
      if (alloc_valid_i && alloc_ready_o) pending_d = pending_d | onehot(alloc_rd_i);
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         rr_ptr_q  <= PTR_W'(NREQ - 1);
         G_q       <= '0;
         R_in_q    <= '0;
         pending_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         G_q       <= G_d;
         R_in_q    <= R_in_d;
         pending_q <= pending_d;
      end
   end

   assign G_o       = G_q;
   assign R_in_o    = R_in_q;
   assign pending_o = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: driver runs an order-list arbitration model and queues
// the expected registered outputs; a negedge monitor pops and compares.
module tb_regfile_wb_arbiter;

   logic        clk = 0, resetn = 0;
   logic [2:0]  req_valid = '0, req_ready;
   logic [14:0] req_rd = '0;
   logic [95:0] req_data = '0;
   logic [31:0] G, R_in, pending;
   logic        alloc_valid = 0, alloc_ready;
   logic [4:0]  alloc_rd = '0;

   regfile_wb_arbiter #(.NREQ(3), .DATA_W(32), .NREGS(32)) dut (
      .clk_i(clk), .resetn_i(resetn),
      .req_valid_i(req_valid), .req_rd_i(req_rd), .req_data_i(req_data),
      .req_ready_o(req_ready), .G_o(G), .R_in_o(R_in),
      .alloc_valid_i(alloc_valid), .alloc_rd_i(alloc_rd),
      .alloc_ready_o(alloc_ready), .pending_o(pending)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0, fails = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   typedef struct {
      int          cyc;
      logic [31:0] r_in, g, pend;
   } exp_t;
   exp_t sbq[$];

   // Reference model: priority order list; the winner moves to the back.
   bit          mpend[32];
   logic [31:0] mG;
   int          mwb;
   int          order[$];
   bit          minit = 0;

   // Driver state, held between cycles.
   bit          drv_rst_n = 0;
   logic [2:0]  drv_v = '0;
   logic [4:0]  drv_rd[3];
   logic [31:0] drv_data[3];
   bit          drv_av = 0;
   logic [4:0]  drv_ard = '0;

   task automatic step(output int g);
      bit          ar;
      logic [31:0] p;
      exp_t        e;
      @(posedge clk); #1;
      resetn = drv_rst_n; req_valid = drv_v;
      for (int i = 0; i < 3; i++) begin
         req_rd[5*i +: 5]    = drv_rd[i];
         req_data[32*i +: 32] = drv_data[i];
      end
      alloc_valid = drv_av; alloc_rd = drv_ard;
      #1;
      g = -1;
      if (drv_rst_n)
         for (int k = 0; k < order.size(); k++)
            if (drv_v[order[k]]) begin g = order[k]; break; end
      check("req_ready", {29'd0, req_ready}, (g >= 0) ? (32'd1 << g) : 32'd0);
      ar = (drv_ard == 0) || !mpend[drv_ard];
      if (minit) check("alloc_ready", {31'd0, alloc_ready}, {31'd0, ar});
      if (!drv_rst_n) begin
         foreach (mpend[r]) mpend[r] = 0;
         mG = 0; mwb = 0; order = {0, 1, 2}; minit = 1;
      end else begin
         if (mwb != 0) mpend[mwb] = 0;
         if (drv_av && ar && drv_ard != 0) mpend[drv_ard] = 1;
         if (g >= 0) begin
            mG = drv_data[g]; mwb = drv_rd[g];
            while (order[order.size()-1] != g) order.push_back(order.pop_front());
         end else mwb = 0;
      end
      if (minit) begin
         p = '0;
         for (int r = 0; r < 32; r++) p[r] = mpend[r];
         e.cyc = cyc + 1; e.r_in = (mwb != 0) ? (32'd1 << mwb) : 32'd0;
         e.g = mG; e.pend = p;
         sbq.push_back(e);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            check("stale_entry", e.cyc, cyc);
         end
         if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            check("R_in", R_in, e.r_in);
            check("G", G, e.g);
            check("pending", pending, e.pend);
         end
      end
   end

   task automatic idle();
      drv_rst_n = 1; drv_v = '0; drv_av = 0; drv_ard = '0;
   endtask

   initial begin : driver
      int g;
      for (int i = 0; i < 3; i++) begin
         drv_rd[i] = 5'(i + 1); drv_data[i] = 32'hA000_0000 + i;
      end
      // Reset with every input active.
      drv_rst_n = 0; drv_v = 3'b111; drv_av = 1; drv_ard = 5'd3;
      repeat (2) step(g);
      // Round-robin under continuous contention, starting at requester 0.
      drv_rst_n = 1; drv_av = 0;
      repeat (6) step(g);
      idle(); step(g);
      // Single write.
      drv_v = 3'b010; drv_rd[1] = 5'd5; drv_data[1] = 32'hDEADBEEF;
      step(g);
      idle(); repeat (2) step(g);
      // Scoreboard set, clear, and same-cycle refused alloc.
      drv_av = 1; drv_ard = 5'd7; step(g);
      drv_av = 0; drv_v = 3'b001; drv_rd[0] = 5'd7; drv_data[0] = 32'h0707_0707; step(g);
      drv_v = '0; drv_av = 1; drv_ard = 5'd7; step(g);
      step(g);
      drv_av = 0; drv_v = 3'b001; step(g);
      idle(); repeat (2) step(g);
      // rd=0 on both paths.
      drv_av = 1; drv_ard = 5'd0; step(g);
      drv_av = 0; drv_v = 3'b100; drv_rd[2] = 5'd0; drv_data[2] = 32'h0000_1234; step(g);
      idle(); step(g);
      // Reset arriving while a write to a pending register is offered.
      drv_av = 1; drv_ard = 5'd9; step(g);
      drv_av = 0; drv_rst_n = 0; drv_v = 3'b001; drv_rd[0] = 5'd9; step(g);
      idle(); repeat (2) step(g);
      // Randomized traffic; requesters hold until granted.
      for (int n = 0; n < 400; n++) begin
         drv_rst_n = ($urandom_range(0, 59) != 0);
         drv_av    = $urandom_range(0, 1) != 0;
         drv_ard   = 5'($urandom_range(0, 9));
         step(g);
         if (g >= 0) drv_v[g] = 1'b0;
         for (int i = 0; i < 3; i++)
            if (!drv_v[i] && $urandom_range(0, 2) != 0) begin
               drv_v[i] = 1'b1;
               drv_rd[i] = 5'($urandom_range(0, 9));
               drv_data[i] = $urandom;
            end
      end
      idle(); repeat (3) step(g);
      @(posedge clk); @(negedge clk); @(negedge clk);
      check("scoreboard_drain", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
